// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into one APB transfer and
// reports completion, read data or a wait-state timeout on a response pulse.
module apb_requester #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int unsigned CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_to_q, rsp_to_d;
  logic [CW-1:0]     wait_q, wait_d;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_to_q    <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_to_q    <= rsp_to_d;
      wait_q      <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_to_d    = rsp_to_q;
    wait_d      = wait_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_to_d    = 1'b0;
        end else if (TIMEOUT > 0 && wait_q == TMAX) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_to_d    = 1'b1;
        end else if (wait_q != '1) begin
          // saturate so TIMEOUT=0 never wraps
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with TIMEOUT=4: vector table of
// single transfers plus back-to-back and mid-transfer reset sequences.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;
  logic        rsp_valid, rsp_timeout, busy;
  logic [31:0] rsp_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  apb_requester #(
    .ADDR_W (12),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        spur;
    int          exp_ps;
    int          exp_pe;
    logic        exp_to;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int   ps, pe;
    logic got;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge pclk);
    chk({t, " ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    prdata    = v.rdata;
    pready    = v.spur;
    ps  = 0;
    pe  = 0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      if (rsp_valid) got = 1'b1;
      else begin
        if (psel) ps++;
        if (penable) pe++;
        pready = penable ? (pe == v.waits + 1) : v.spur;
      end
    end
    chk({t, " rsp_seen"}, 32'(got), 32'd1);
    chk({t, " psel_cyc"}, 32'(ps), 32'(v.exp_ps));
    chk({t, " pen_cyc"}, 32'(pe), 32'(v.exp_pe));
    chk({t, " rsp_to"}, 32'(rsp_timeout), 32'(v.exp_to));
    chk({t, " rsp_rd"}, rsp_rdata, v.exp_rd);
    chk({t, " idle"}, {30'd0, psel, cmd_ready}, 32'd1);
    chk({t, " paddr"}, 32'(paddr), 32'(v.addr));
    chk({t, " pwrite"}, 32'(pwrite), 32'(v.wr));
    chk({t, " pwdata"}, pwdata, v.wdata);
    pready = 1'b0;
    @(negedge pclk);
    chk({t, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({t, " rd_hold"}, rsp_rdata, v.exp_rd);
    chk({t, " to_hold"}, 32'(rsp_timeout), 32'(v.exp_to));
  endtask

  initial begin
    int   r1, r2, nrsp, nv;
    logic prev;

    tbl[0] = '{1'b1, 12'h004, 32'h0000_0001, 32'hDEAD_BEEF,
               0, 1'b0, 2, 1, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 12'h008, 32'h1111_0000, 32'h0000_00A5,
               3, 1'b0, 5, 4, 1'b0, 32'h0000_00A5};
    tbl[2] = '{1'b0, 12'h010, 32'h2222_0000, 32'h7777_7777,
               9, 1'b0, 5, 4, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 12'h00C, 32'h3333_0000, 32'h1234_5678,
               0, 1'b0, 2, 1, 1'b0, 32'h1234_5678};
    tbl[4] = '{1'b0, 12'h020, 32'h4444_0000, 32'h0000_5A5A,
               0, 1'b1, 2, 1, 1'b0, 32'h0000_5A5A};
    tbl[5] = '{1'b1, 12'hFFF, 32'hCAFE_BABE, 32'hFFFF_FFFF,
               2, 1'b1, 4, 3, 1'b0, 32'h0};

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    #12;
    chk("rst psel", {30'd0, psel, penable}, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
    chk("rst bus", {19'd0, pwrite, paddr}, 32'd0);
    chk("rst pwdata", pwdata, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    chk("rel ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) run(tbl[i], i);

    // back-to-back: cmd_valid held across two commands
    @(negedge pclk);
    pready    = 1'b1;
    prdata    = 32'h0BAD_F00D;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h000;
    cmd_wdata = 32'h0000_0055;
    prev = 1'b0;
    r1   = -1;
    r2   = -1;
    nrsp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 1) begin
          chk("b2b ready", 32'(cmd_ready), 32'd1);
          chk("b2b rd0", rsp_rdata, 32'd0);
        end
      end
      if (psel && !prev) begin
        if (r1 < 0) begin
          r1 = c;
          cmd_write = 1'b0;
          cmd_addr  = 12'h00C;
        end else if (r2 < 0) begin
          r2 = c;
          cmd_valid = 1'b0;
          chk("b2b addr2", 32'(paddr), 32'h00C);
          chk("b2b wr2", 32'(pwrite), 32'd0);
        end
      end
      prev = psel;
    end
    chk("b2b gap", 32'(r2 - r1), 32'd3);
    chk("b2b nrsp", 32'(nrsp), 32'd2);
    chk("b2b rd1", rsp_rdata, 32'h0BAD_F00D);
    pready = 1'b0;

    // reset while penable is high
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h0AA;
    nv = 0;
    for (int c = 0; c < 10 && !penable; c++) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      nv++;
    end
    chk("mid pen", 32'(penable), 32'd1);
    #2;
    preset = 1'b1;
    #1;
    chk("mid psel", {30'd0, psel, penable}, 32'd0);
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid paddr", 32'(paddr), 32'd0);
    pready = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      if (rsp_valid) nrsp++;
    end
    chk("mid norsp", 32'(nrsp), 32'd0);
    chk("mid ready", 32'(cmd_ready), 32'd1);
    pready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
